// File: rtl/counter_access_ctrl.sv
// counter_access_ctrl
//   CPU-side access controller for one counter channel of an 8254-style timer.
//   It decodes control words and data writes, assembles the 16-bit count register
//   for the counting element, and serves byte reads of either the live count or a
//   latched snapshot.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   databus     in   8   CPU data byte
//   a           in   2   register address (2'b11 = control word)
//   wr_pulse    in   1   one-cycle write strobe
//   rd_pulse    in   1   one-cycle read strobe
//   ce_count    in  16   live count from the counting element
//   ce_loaded   in   1   counting element has taken cr_value
//   cr_value    out 16   assembled count register value
//   load_strobe out  1   one-cycle pulse, cr_value is complete
//   dout        out  8   read data byte
//   mode        out  3   programmed counter mode
//   bcd         out  1   programmed BCD flag
//   null_count  out  1   count written but not yet loaded by the counting element
module counter_access_ctrl #(
    parameter logic [1:0] COUNTER_ID = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  databus,
    input  logic [1:0]  a,
    input  logic        wr_pulse,
    input  logic        rd_pulse,
    input  logic [15:0] ce_count,
    input  logic        ce_loaded,
    output logic [15:0] cr_value,
    output logic        load_strobe,
    output logic [7:0]  dout,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic        null_count
);

    localparam logic [1:0] ST_UNPROG = 2'd0;
    localparam logic [1:0] ST_W_LSB  = 2'd1;
    localparam logic [1:0] ST_W_MSB  = 2'd2;

    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    logic [1:0]  r_wstate;
    logic [1:0]  r_rw;
    logic        r_rd_msb;     // read byte pointer, 1 = next read returns MSB
    logic        r_latched;
    logic [15:0] r_latch;
    logic [15:0] r_cr;
    logic        r_load;
    logic [7:0]  r_dout;
    logic [2:0]  r_mode;
    logic        r_bcd;
    logic        r_null;

    logic        w_ctrl_sel;
    logic        w_ctrl_prog;
    logic        w_ctrl_latch;
    logic        w_data_wr;
    logic        w_data_rd;
    logic [2:0]  w_mode_fix;
    logic [15:0] w_rd_src;
    logic        w_rd_hi;
    logic        w_rd_last;

    always_comb begin
        w_ctrl_sel   = wr_pulse && (a == 2'b11) && (databus[7:6] == COUNTER_ID);
        w_ctrl_prog  = w_ctrl_sel && (databus[5:4] != RW_LATCH);
        w_ctrl_latch = w_ctrl_sel && (databus[5:4] == RW_LATCH);
        // Writes are dropped until the channel has been programmed.
        w_data_wr    = wr_pulse && (a == COUNTER_ID) && (r_wstate != ST_UNPROG);
        // A write in the same cycle takes priority over the read.
        w_data_rd    = rd_pulse && !wr_pulse && (a == COUNTER_ID);
        // Modes 6 and 7 alias onto 2 and 3.
        w_mode_fix   = (databus[3:2] == 2'b11) ? {1'b0, databus[2:1]} : databus[3:1];
        w_rd_src     = r_latched ? r_latch : ce_count;
        w_rd_hi      = (r_rw == RW_MSB) || ((r_rw == RW_BOTH) && r_rd_msb);
        w_rd_last    = (r_rw != RW_BOTH) || r_rd_msb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= ST_UNPROG;
            r_rw      <= RW_LATCH;
            r_rd_msb  <= 1'b0;
            r_latched <= 1'b0;
            r_latch   <= 16'h0000;
            r_cr      <= 16'h0000;
            r_load    <= 1'b0;
            r_dout    <= 8'h00;
            r_mode    <= 3'd0;
            r_bcd     <= 1'b0;
            r_null    <= 1'b0;
        end else begin
            r_load <= 1'b0;

            if (w_ctrl_prog) begin
                r_rw      <= databus[5:4];
                r_mode    <= w_mode_fix;
                r_bcd     <= databus[0];
                r_cr      <= 16'h0000;
                r_latched <= 1'b0;
                r_wstate  <= ST_W_LSB;
                r_rd_msb  <= 1'b0;
            end else if (w_ctrl_latch) begin
                // Only the first latch command is honoured until it has been read out.
                if (!r_latched) begin
                    r_latch   <= ce_count;
                    r_latched <= 1'b1;
                end
            end else if (w_data_wr) begin
                unique case (r_rw)
                    RW_LSB: begin
                        r_cr   <= {8'h00, databus};
                        r_load <= 1'b1;
                    end
                    RW_MSB: begin
                        r_cr   <= {databus, 8'h00};
                        r_load <= 1'b1;
                    end
                    RW_BOTH: begin
                        if (r_wstate == ST_W_LSB) begin
                            r_cr[7:0] <= databus;
                            r_wstate  <= ST_W_MSB;
                        end else begin
                            r_cr[15:8] <= databus;
                            r_load     <= 1'b1;
                            r_wstate   <= ST_W_LSB;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // A write in the same cycle as ce_loaded keeps the count marked null.
            if (w_ctrl_prog || w_data_wr) begin
                r_null <= 1'b1;
            end else if (ce_loaded) begin
                r_null <= 1'b0;
            end

            if (w_data_rd) begin
                if (r_wstate == ST_UNPROG) begin
                    r_dout <= 8'h00;
                end else begin
                    r_dout <= w_rd_hi ? w_rd_src[15:8] : w_rd_src[7:0];
                    if (r_rw == RW_BOTH) begin
                        r_rd_msb <= !r_rd_msb;
                    end
                    if (w_rd_last) begin
                        r_latched <= 1'b0;
                    end
                end
            end
        end
    end

    assign cr_value    = r_cr;
    assign load_strobe = r_load;
    assign dout        = r_dout;
    assign mode        = r_mode;
    assign bcd         = r_bcd;
    assign null_count  = r_null;

endmodule

// File: doc/counter_access_ctrl.md
COUNTER_ACCESS_CTRL -- requirements
Module: counter_access_ctrl

Interface
REQ-001 SHALL have parameter COUNTER_ID, default 2'b00, which is the counter select matched against address and control-word SC field.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port databus  in  8  CPU data byte.
REQ-005 SHALL have port a  in  2  register address; 2'b11 selects the control word.
REQ-006 SHALL have port wr_pulse  in  1  one-cycle write strobe.
REQ-007 SHALL have port rd_pulse  in  1  one-cycle read strobe.
REQ-008 SHALL have port ce_count  in  16  live count from the counting element.
REQ-009 SHALL have port ce_loaded  in  1  one-cycle pulse indicating the counting element took cr_value.
REQ-010 SHALL have port cr_value  out  16  assembled count register value.
REQ-011 SHALL have port load_strobe  out  1  one-cycle pulse indicating that cr_value is complete.
REQ-012 SHALL have port dout  out  8  read data byte.
REQ-013 SHALL have port mode  out  3  programmed counter mode.
REQ-014 SHALL have port bcd  out  1  programmed BCD flag.
REQ-015 SHALL have port null_count  out  1  indicates that the count is written but not yet loaded into the counting element.

Function
REQ-016 SHALL treat a control word as wr_pulse with a==2'b11 and databus[7:6]=={1'b0,COUNTER_ID}; other control words SHALL be ignored.
REQ-017 SHALL, on a control word with RW=databus[5:4]!=00, set rw_mode<=RW, mode<=databus[3:1] (6->2, 7->3), bcd<=databus[0], cr_value<=0, null_count<=1, cancel any latch, and set both write and read byte pointers to LSB.
REQ-018 SHALL, on a control word with RW==00 (latch), capture ce_count into a 16-bit output latch and set latched=1 only if no latch is pending; a second latch command while latched SHALL be ignored.
REQ-019 SHALL use write FSM states UNPROG (reset state, data writes ignored), W_LSB, and W_MSB.
REQ-020 SHALL treat a data write as wr_pulse with a==COUNTER_ID.
REQ-021 SHALL, for rw_mode 01, write databus to cr_value[7:0], clear cr_value[15:8], and pulse load_strobe.
REQ-022 SHALL, for rw_mode 10, write databus to cr_value[15:8], clear cr_value[7:0], and pulse load_strobe.
REQ-023 SHALL, for rw_mode 11, on the W_LSB write update cr_value[7:0] and go to W_MSB without a load pulse; on the W_MSB write update cr_value[15:8], pulse load_strobe, and return to W_LSB.
REQ-024 SHALL assert load_strobe for exactly one cycle, in the cycle after the completing wr_pulse, with cr_value already updated in that cycle.
REQ-025 SHALL set null_count=1 on every data write and SHALL clear it on ce_loaded; if both occur in the same cycle, the write SHALL win (null_count=1).
REQ-026 SHALL treat a data read as rd_pulse with a==COUNTER_ID, using the output latch as source if latched=1 and ce_count otherwise.
REQ-027 SHALL, for reads, return the LSB for rw_mode 01, the MSB for rw_mode 10, and for rw_mode 11 alternate LSB then MSB using the read byte pointer.
REQ-028 SHALL register dout in the cycle after rd_pulse and hold it until the next read; in UNPROG, dout SHALL be 8'h00.
REQ-029 SHALL clear latched after the final byte of a read (one byte for rw_mode 01/10, the MSB byte for rw_mode 11).
REQ-030 SHALL, when wr_pulse and rd_pulse coincide, perform the write and ignore the read.
REQ-031 SHALL, on a control word received mid-sequence (in W_MSB or with the read pointer at MSB), abort the sequence with no load_strobe and apply REQ-017/REQ-018; a latch command SHALL NOT reset the write FSM.
REQ-032 SHALL change nothing on a data write to a different COUNTER_ID or on rd_pulse with a==2'b11.

Reset
REQ-033 SHALL, on reset asserted at any time, immediately clear cr_value=0, load_strobe=0, dout=0, mode=0, bcd=0, null_count=0, latched=0, and set write FSM=UNPROG and read pointer=LSB, aborting any partial sequence.
REQ-034 SHALL, after reset release, ignore all data writes until a valid control word is received.

Verification
REQ-035 SHALL be verified by: reset, control 8'h34 (counter 0, RW=11, mode 2), writes 8'hCD then 8'hAB -> no load_strobe after the first write; cr_value=16'hABCD with a single load_strobe one cycle after the second write; null_count=1 until ce_loaded.
REQ-036 SHALL be verified by: control 8'h10 (RW=01), write 8'h55 -> cr_value=16'h0055 and load_strobe the next cycle; control 8'h20, write 8'h77 -> cr_value=16'h7700.
REQ-037 SHALL be verified by: RW=11 with ce_count=16'h1234, latch 8'h00, ce_count changed to 16'h9999, latch again, two reads -> dout 8'h34 then 8'h12; a third read gives live 8'h99.
REQ-038 SHALL be verified by: RW=11, write 8'h11, new control word 8'h36, write 8'h22 then 8'h33 -> cr_value=16'h3322 and exactly one load_strobe; mode=3.
REQ-039 SHALL be verified by: reset asserted in W_MSB -> all outputs 0 asynchronously; a data write after release is ignored (cr_value stays 0).
REQ-040 SHALL be verified by: coincident wr_pulse and rd_pulse -> the write is applied and dout is unchanged; coincident data write and ce_loaded -> null_count=1.
